// File: rtl/dbus_wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dbus_pkg
// Purpose  : Shared types and constants for the data-bus Wishbone initiator.
// Revision : 1.0 - initial release
// ============================================================================
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } dbus_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_size_t;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  // Undefined encodings behave as word accesses, so they share the word rule.
  function automatic logic is_misaligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (fun3)
      LB, LBU: r = 1'b0;
      LH, LHU: r = addr_lo[0];
      default: r = (addr_lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_wb_master_lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Byte-lane steering for stores and lane extract/extend for loads.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import dbus_pkg::*;
(
  input  logic [2:0]  i_fun3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // fun3[2] distinguishes the unsigned load variants.
  always_comb begin
    o_sel   = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_fun3)
      LB, LBU: begin
        o_sel   = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_fun3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      LH, LHU: begin
        o_sel   = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_fun3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_sel   = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

  assign o_misaligned = is_misaligned(i_fun3, i_addr_lo);

endmodule
`default_nettype wire

// File: rtl/dbus_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : dbus_wb_master
// Purpose  : MEM-stage load/store initiator running Wishbone classic single
//            transfers; optional ack timeout enabled by DBUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_wb_master
  import dbus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [2:0]        fun3_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [31:0]       wdata_mem,
  output logic [31:0]       rdata_mem,
  output logic              stall_pipl,
  output logic              misaligned_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  output logic              bus_err_o
);

  dbus_state_t       r_state, w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [3:0]        r_sel;
  logic [31:0]       r_dat;
  logic [2:0]        r_fun3;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_rdata;
  logic              r_misal;

  logic              w_req, w_misal, w_start, w_suppress, w_ack, w_timeout;
  logic [2:0]        w_fun3;
  logic [1:0]        w_addr_lo;
  logic [3:0]        w_sel;
  logic [31:0]       w_wdat, w_load;

  assign w_req = mem_read_mem | mem_write_mem;

  // The aligner sees the live request while idle and the latched access after.
  assign w_fun3    = (r_state == IDLE) ? fun3_mem      : r_fun3;
  assign w_addr_lo = (r_state == IDLE) ? addr_mem[1:0] : r_addr_lo;

  lsu_lane_align u_align (
    .i_fun3       (w_fun3),
    .i_addr_lo    (w_addr_lo),
    .i_wdata      (wdata_mem),
    .i_rdata      (wb_dat_i),
    .o_sel        (w_sel),
    .o_wdata      (w_wdat),
    .o_rdata      (w_load),
    .o_misaligned (w_misal)
  );

  assign w_start    = (r_state == IDLE) && w_req && !w_misal;
  assign w_suppress = (r_state == IDLE) && w_req &&  w_misal;
  assign w_ack      = (r_state == BUS)  && wb_ack_i;

`ifdef DBUS_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;

  assign w_timeout = (r_state == BUS) && !wb_ack_i && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_start)
        r_cnt <= '0;
      else if (r_state == BUS)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus_err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // DONE always returns to IDLE: the instruction that just completed is still in MEM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = BUS;
      BUS:     if (w_ack || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_sel     <= 4'b0000;
      r_dat     <= 32'h0;
      r_fun3    <= 3'b000;
      r_addr_lo <= 2'b00;
      r_rdata   <= 32'h0;
      r_misal   <= 1'b0;
    end else begin
      r_misal <= w_suppress;
      if (w_start) begin
        r_we      <= mem_write_mem;
        r_adr     <= {addr_mem[ADDR_W-1:2], 2'b00};
        r_sel     <= w_sel;
        r_dat     <= w_wdat;
        r_fun3    <= fun3_mem;
        r_addr_lo <= addr_mem[1:0];
      end
      if (w_suppress)
        r_rdata <= 32'h0;
      else if (w_ack && !r_we)
        r_rdata <= w_load;
      else if (w_timeout && !r_we)
        r_rdata <= TIMEOUT_FILL;
    end
  end

  assign stall_pipl   = w_start || (r_state == BUS);
  assign wb_cyc_o     = (r_state == BUS);
  assign wb_stb_o     = (r_state == BUS);
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_sel_o     = r_sel;
  assign wb_dat_o     = r_dat;
  assign rdata_mem    = r_rdata;
  assign misaligned_o = r_misal;

endmodule
`default_nettype wire

// File: doc/dbus_wb_master.md
Name: dbus_wb_master

Overview:
- Data-side bus initiator for the pipelined core's MEM stage.
- Accepts load/store requests from MEM and runs Wishbone classic single transfers.
- Drives `stall_pipl` into the control unit to freeze the pipeline until the transfer completes.
- Performs byte-lane steering on stores and lane extraction with sign/zero extension on loads.

Parameters:
- ADDR_W, 32, byte-address width of `addr_mem` and `wb_adr_o`.
- TIMEOUT_CYCLES, 255, cycles spent in BUS waiting for ack before abort (used only with the optional feature).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- mem_read_mem  in  1  load in MEM stage
- mem_write_mem  in  1  store in MEM stage
- fun3_mem  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr_mem  in  ADDR_W  byte address
- wdata_mem  in  32  store data (right-aligned)
- rdata_mem  out  32  extended load result
- stall_pipl  out  1  pipeline freeze request
- misaligned_o  out  1  one-cycle pulse: misaligned access suppressed
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- wb_dat_o  out  32  lane-replicated store data
- wb_sel_o  out  4  byte selects
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  transfer acknowledge
- bus_err_o  out  1  timeout pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset (async, immediate): state IDLE; cyc/stb/we=0; adr/dat/sel=0; rdata_mem=0; stall_pipl=0; misaligned_o=0; bus_err_o=0. A transfer in flight is dropped with no completion.
- FSM states: IDLE, BUS, DONE.
- **IDLE:**
  - req = mem_read_mem | mem_write_mem. If both are set, treat as a write.
  - Aligned req: `stall_pipl` = 1 combinationally in the same cycle. Register we, word address, sel, replicated data and fun3. Next state BUS.
  - Misaligned req (halfword with addr[0]=1, or word with addr[1:0]≠0): no bus cycle, no stall. `misaligned_o` pulses next cycle. `rdata_mem` is cleared to 0. Stay IDLE.
- **BUS:**
  - cyc=stb=1, registered signals held stable, `stall_pipl` = 1.
  - On wb_ack_i=1 (sampled at posedge): for a read, latch the extended load into `rdata_mem`. Drop cyc/stb next cycle. Next state DONE.
- **DONE:**
  - `stall_pipl` = 0, so the pipeline advances at this edge.
  - New requests are ignored this cycle: the same instruction is still in MEM.
  - Next state IDLE.
- Zero-wait slave (ack in first BUS cycle): 2 stall cycles per access. Each wait state adds 1.
- `rdata_mem` holds its value until the next completed load or a misaligned suppression.
- Store lanes: SB replicates byte ×4, sel = 0001<<addr[1:0]; SH replicates half ×2, sel = 0011<<{addr[1],0}; SW sel = 1111.
- Load extract: select lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Undefined fun3 (011, 110, 111) is treated as LW/SW.
- wb_ack_i outside BUS is ignored.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to BUS and increments every BUS cycle.
  - Reaching TIMEOUT_CYCLES without ack: drop cyc/stb, pulse `bus_err_o` one cycle, and for a read set `rdata_mem` = 32'hDEAD_BEEF. Next state DONE.
- Undefined: no counter; BUS waits indefinitely; `bus_err_o` tied 0.

Decomposition:
- Package `dbus_pkg` holds:
  - `dbus_state_t` enum {IDLE, BUS, DONE}
  - `mem_size_t` fun3 encodings (LB, LH, LW, LBU, LHU)
  - `TIMEOUT_FILL` = 32'hDEAD_BEEF
- One combinational sub-module `lsu_lane_align`: inputs fun3, addr[1:0], wdata, wb_dat_i; outputs sel, replicated store data, extended load data, misaligned flag.
- The FSM stays in `dbus_wb_master`.

Test Plan:
- SW addr=0x100 data=0x11223344, ack in first BUS cycle -> adr=0x100, sel=1111, dat_o=0x11223344, we=1; stall_pipl high exactly 2 cycles.
- LB addr=0x203, wb_dat_i=0x80FF_0000, ack after 3 waits -> sel=1000; rdata_mem=0xFFFF_FF80; stall_pipl high 5 cycles.
- LHU addr=0x202, wb_dat_i=0x9ABC_0000 -> sel=1100, rdata_mem=0x0000_9ABC. SH addr=0x202 data=0x0000_BEEF -> dat_o=0xBEEF_BEEF, sel=1100.
- LW addr=0x101 -> no cyc, stall_pipl=0, misaligned_o pulses once, rdata_mem=0.
- reset_n dropped mid-BUS -> cyc/stb deassert asynchronously; after release, a new LW completes normally.
- With DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack on LW -> bus_err_o pulses after 4 BUS cycles; rdata_mem=0xDEADBEEF; stall_pipl releases the following cycle.
